// File: rtl/lc3_int_arbiter.sv
// ---------------------------------------------------------------------------
// lc3_int_arbiter
//
// Multi-channel interrupt arbiter for the LC-3 core. It replaces the single
// INT input of the control FSM with NUM_CH sources. Each source has its own
// priority, enable bit and trigger mode (rising-edge or level). The winning
// request must beat the current PSR priority. It is then presented to the
// control unit as INT/INTV/intPri and held until the FSM acknowledges it in
// state INT0.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   irqReq   raw request lines, one bit per source
//   cfgWE    configuration write strobe
//   cfgCh    channel index for the write (indices >= NUM_CH are ignored)
//   cfgPri   priority to write
//   cfgEn    enable bit to write
//   cfgEdge  trigger mode to write (1 = rising-edge, 0 = level)
//   curPri   current PSR[10:8]
//   intAck   one-cycle acknowledge from the control FSM (INT0)
//   INT      interrupt request to the control FSM
//   INTV     vector of the presented request
//   intPri   priority of the presented request (loaded into PSR on ack)
//   pending  current pending bits, for status/debug
// ---------------------------------------------------------------------------
module lc3_int_arbiter #(
  parameter int                NUM_CH   = 8,
  parameter int                PRI_W    = 3,
  parameter int                VEC_W    = 8,
  parameter logic [VEC_W-1:0]  VEC_BASE = 8'h80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   irqReq,
  input  logic                cfgWE,
  input  logic [3:0]          cfgCh,
  input  logic [PRI_W-1:0]    cfgPri,
  input  logic                cfgEn,
  input  logic                cfgEdge,
  input  logic [PRI_W-1:0]    curPri,
  input  logic                intAck,
  output logic                INT,
  output logic [VEC_W-1:0]    INTV,
  output logic [PRI_W-1:0]    intPri,
  output logic [NUM_CH-1:0]   pending
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } stateT;

  stateT              state;

  logic [PRI_W-1:0]   chPri [NUM_CH];
  logic [NUM_CH-1:0]  chEn;
  logic [NUM_CH-1:0]  chEdge;
  logic [NUM_CH-1:0]  pendReg;
  logic [NUM_CH-1:0]  irqPrev;
  logic [3:0]         latchIdx;

  logic [NUM_CH-1:0]  eligible;
  logic [NUM_CH-1:0]  ackClr;
  logic               anyElig;
  logic [3:0]         winIdx;
  logic [PRI_W-1:0]   winPri;

  assign pending = pendReg;

  // Arbitration. A channel is a candidate when it is pending, enabled and
  // strictly above the current PSR priority, so priority 0 can never win.
  // Scanning upward and replacing only on a strictly higher priority makes
  // the lowest index win a tie. ackClr marks the committed channel's pending
  // bit for clearing when the FSM acknowledges it, but only in edge mode;
  // a level source has to drop its line itself.
  always_comb begin
    eligible = '0;
    ackClr   = '0;
    anyElig  = 1'b0;
    winIdx   = '0;
    winPri   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = pendReg[i] & chEn[i] & (chPri[i] > curPri);
      ackClr[i]   = (state == REQ) && intAck && (latchIdx == 4'(i)) && chEdge[i];
      if (eligible[i] && (!anyElig || (chPri[i] > winPri))) begin
        anyElig = 1'b1;
        winIdx  = 4'(i);
        winPri  = chPri[i];
      end
    end
  end

  // Per-channel configuration registers. A write to a channel index that
  // does not exist matches no channel and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        chPri[i] <= '0;
      end
      chEn   <= '0;
      chEdge <= '0;
    end else if (cfgWE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfgCh == 4'(i)) begin
          chPri[i]  <= cfgPri;
          chEn[i]   <= cfgEn;
          chEdge[i] <= cfgEdge;
        end
      end
    end
  end

  // Pending bits. Edge channels latch a rising edge and clear on
  // acknowledge. The set term is ORed in after the clear, so an edge that
  // lands in the acknowledge cycle survives. Level channels follow the line.
  // Edges still latch while a channel is disabled; enable only masks
  // arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      pendReg <= '0;
      irqPrev <= '0;
    end else begin
      irqPrev <= irqReq;
      for (int i = 0; i < NUM_CH; i++) begin
        if (chEdge[i]) begin
          pendReg[i] <= (pendReg[i] & ~ackClr[i]) | (irqReq[i] & ~irqPrev[i]);
        end else begin
          pendReg[i] <= irqReq[i];
        end
      end
    end
  end

  // Request FSM with registered outputs. Once a request is presented in REQ
  // it is committed and frozen. Nothing but the acknowledge (or reset)
  // releases it, even a higher-priority arrival. HOLD gives the PSR one cycle
  // to take the new priority before the next arbitration. INTV and intPri
  // keep their last values until the next request reloads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      INT      <= 1'b0;
      INTV     <= '0;
      intPri   <= '0;
      latchIdx <= '0;
    end else begin
      case (state)
        IDLE: begin
          INT <= 1'b0;
          if (anyElig) begin
            INT      <= 1'b1;
            INTV     <= VEC_BASE + VEC_W'(winIdx);
            intPri   <= winPri;
            latchIdx <= winIdx;
            state    <= REQ;
          end
        end
        REQ: begin
          if (intAck) begin
            INT   <= 1'b0;
            state <= HOLD;
          end
        end
        HOLD: begin
          INT   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          INT   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_int_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lc3_int_arbiter
//
// Self-checking bench for lc3_int_arbiter. A behavioural model tracks the
// per-channel configuration, the pending events and the outstanding request.
// It also counts the cooldown cycle that follows an acknowledge. The model
// is stepped once per clock with the same inputs as the DUT. All four
// outputs are compared every cycle. The directed scenarios from the feature
// list run first; a randomized run follows.
// ---------------------------------------------------------------------------
module tb_lc3_int_arbiter;

  localparam int NUM_CH   = 8;
  localparam int PRI_W    = 3;
  localparam int VEC_W    = 8;
  localparam int VEC_BASE = 'h80;

  logic               clk;
  logic               rst;
  logic [NUM_CH-1:0]  irqReq;
  logic               cfgWE;
  logic [3:0]         cfgCh;
  logic [PRI_W-1:0]   cfgPri;
  logic               cfgEn;
  logic               cfgEdge;
  logic [PRI_W-1:0]   curPri;
  logic               intAck;
  logic               INT;
  logic [VEC_W-1:0]   INTV;
  logic [PRI_W-1:0]   intPri;
  logic [NUM_CH-1:0]  pending;

  int checks;
  int errors;

  // Reference model state
  int  mPri  [NUM_CH];
  bit  mEn   [NUM_CH];
  bit  mEdge [NUM_CH];
  bit  mPend [NUM_CH];
  bit  mPrev [NUM_CH];
  bit  mInt;
  int  mVec;
  int  mIntPri;
  int  mIdx;
  int  mCool;

  lc3_int_arbiter #(
    .NUM_CH   (NUM_CH),
    .PRI_W    (PRI_W),
    .VEC_W    (VEC_W),
    .VEC_BASE (8'h80)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .irqReq  (irqReq),
    .cfgWE   (cfgWE),
    .cfgCh   (cfgCh),
    .cfgPri  (cfgPri),
    .cfgEn   (cfgEn),
    .cfgEdge (cfgEdge),
    .curPri  (curPri),
    .intAck  (intAck),
    .INT     (INT),
    .INTV    (INTV),
    .intPri  (intPri),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Search from the highest priority downward. Within one priority the
  // first (lowest) index found is the winner. Only priorities strictly above
  // curPri are searched.
  function automatic int pickWinner();
    for (int p = (1 << PRI_W) - 1; p > int'(curPri); p--) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (mPend[i] && mEn[i] && mPri[i] == p) return i;
      end
    end
    return -1;
  endfunction

  // Advance the model by one clock using the inputs present at the edge
  task automatic modelStep();
    int win;
    int c;
    bit clr [NUM_CH];
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mPri[i] = 0; mEn[i] = 0; mEdge[i] = 0; mPend[i] = 0; mPrev[i] = 0;
      end
      mInt = 0; mVec = 0; mIntPri = 0; mIdx = 0; mCool = 0;
      return;
    end
    win = pickWinner();
    for (int i = 0; i < NUM_CH; i++) clr[i] = 0;
    if (mInt) begin
      if (intAck) begin
        mInt  = 0;
        mCool = 1;
        if (mEdge[mIdx]) clr[mIdx] = 1;
      end
    end else if (mCool > 0) begin
      mCool--;
    end else if (win >= 0) begin
      mInt    = 1;
      mIdx    = win;
      mVec    = (VEC_BASE + win) % (1 << VEC_W);
      mIntPri = mPri[win];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (mEdge[i]) mPend[i] = (mPend[i] && !clr[i]) || (irqReq[i] && !mPrev[i]);
      else          mPend[i] = irqReq[i];
    end
    c = int'(cfgCh);
    if (cfgWE && c < NUM_CH) begin
      mPri[c]  = int'(cfgPri);
      mEn[c]   = cfgEn;
      mEdge[c] = cfgEdge;
    end
    for (int i = 0; i < NUM_CH; i++) mPrev[i] = irqReq[i];
  endtask

  // One clock: DUT and model see the same inputs. Outputs are compared just
  // after the edge. One-shot strobes are released at the next falling edge.
  task automatic applyStimulus();
    logic [NUM_CH-1:0] expPend;
    @(posedge clk);
    modelStep();
    #1;
    for (int i = 0; i < NUM_CH; i++) expPend[i] = mPend[i];
    checkOutput("INT",     32'(INT),     32'(mInt));
    checkOutput("INTV",    32'(INTV),    32'(mVec));
    checkOutput("intPri",  32'(intPri),  32'(mIntPri));
    checkOutput("pending", 32'(pending), 32'(expPend));
    @(negedge clk);
    cfgWE  = 1'b0;
    intAck = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic configure(input int ch, input int pri, input bit en, input bit edgeMode);
    cfgWE   = 1'b1;
    cfgCh   = 4'(ch);
    cfgPri  = PRI_W'(pri);
    cfgEn   = en;
    cfgEdge = edgeMode;
    applyStimulus();
  endtask

  task automatic doReset();
    rst    = 1'b1;
    irqReq = '0;
    curPri = '0;
    applyStimulus();
  endtask

  task automatic ackOnce();
    intAck = 1'b1;
    applyStimulus();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    irqReq  = '0;
    cfgWE   = 1'b0;
    cfgCh   = '0;
    cfgPri  = '0;
    cfgEn   = 1'b0;
    cfgEdge = 1'b0;
    curPri  = '0;
    intAck  = 1'b0;
    @(negedge clk);

    doReset();
    checkOutput("rst_INT",     32'(INT),     32'h0);
    checkOutput("rst_INTV",    32'(INTV),    32'h0);
    checkOutput("rst_pending", 32'(pending), 32'h0);

    $display("[TB] edge channel 3 basic request");
    configure(3, 5, 1, 1);
    curPri = 3'd2;
    irqReq[3] = 1'b1;
    applyStimulus();
    checkOutput("s1_pend3", 32'(pending[3]), 32'h1);
    checkOutput("s1_intLow", 32'(INT), 32'h0);
    irqReq[3] = 1'b0;
    applyStimulus();
    checkOutput("s1_INT", 32'(INT), 32'h1);
    checkOutput("s1_INTV", 32'(INTV), 32'h83);
    checkOutput("s1_intPri", 32'(intPri), 32'h5);
    applyStimulus();
    ackOnce();
    checkOutput("s1_ackINT", 32'(INT), 32'h0);
    checkOutput("s1_ackPend", 32'(pending[3]), 32'h0);
    applyStimulus();
    applyStimulus();

    $display("[TB] equal-priority tie on channels 1 and 6");
    doReset();
    configure(1, 4, 1, 1);
    configure(6, 4, 1, 1);
    irqReq = 8'b0100_0010;
    applyStimulus();
    applyStimulus();
    checkOutput("s2_first", 32'(INTV), 32'h81);
    ackOnce();
    applyStimulus();
    applyStimulus();
    checkOutput("s2_secondINT", 32'(INT), 32'h1);
    checkOutput("s2_second", 32'(INTV), 32'h86);
    ackOnce();
    applyStimulus();

    $display("[TB] priority equal to curPri is blocked");
    doReset();
    configure(2, 3, 1, 1);
    curPri = 3'd3;
    irqReq[2] = 1'b1;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("s3_blocked", 32'(INT), 32'h0);
    curPri = 3'd2;
    applyStimulus();
    checkOutput("s3_unblocked", 32'(INT), 32'h1);
    ackOnce();

    $display("[TB] level channel 0 held through acknowledge");
    doReset();
    configure(0, 7, 1, 0);
    irqReq[0] = 1'b1;
    applyStimulus();
    applyStimulus();
    ackOnce();
    applyStimulus();
    applyStimulus();
    checkOutput("s4_reassert", 32'(INT), 32'h1);
    checkOutput("s4_vec", 32'(INTV), 32'h80);
    irqReq[0] = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("s4_committed", 32'(INT), 32'h1);
    ackOnce();
    applyStimulus();

    $display("[TB] committed request is not replaced");
    doReset();
    configure(4, 2, 1, 1);
    configure(5, 6, 1, 1);
    irqReq[4] = 1'b1;
    applyStimulus();
    applyStimulus();
    irqReq[5] = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("s5_frozenVec", 32'(INTV), 32'h84);
    checkOutput("s5_frozenPri", 32'(intPri), 32'h2);
    ackOnce();
    applyStimulus();
    applyStimulus();
    checkOutput("s5_nextVec", 32'(INTV), 32'h85);
    checkOutput("s5_nextPri", 32'(intPri), 32'h6);

    $display("[TB] reset while a request is presented");
    doReset();
    checkOutput("s6_INT", 32'(INT), 32'h0);
    checkOutput("s6_pending", 32'(pending), 32'h0);
    irqReq[5] = 1'b1;
    applyStimulus();
    irqReq[5] = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("s6_noInt", 32'(INT), 32'h0);

    $display("[TB] randomized run");
    doReset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 7) == 0) irqReq[i] = ~irqReq[i];
      end
      if ($urandom_range(0, 5) == 0) begin
        cfgWE   = 1'b1;
        cfgCh   = 4'($urandom_range(0, 15));
        cfgPri  = PRI_W'($urandom_range(0, 7));
        cfgEn   = ($urandom_range(0, 3) != 0);
        cfgEdge = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 9) == 0) curPri = PRI_W'($urandom_range(0, 6));
      if (mInt) intAck = ($urandom_range(0, 2) == 0);
      else      intAck = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
